// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle RV32I core.
// Optional illegal-opcode halt state: define MULTICYCLE_ILLEGAL_TRAP_EN.
module multicycle_ctrl #(
    parameter int OPW   = 7,
    parameter int ALUCW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [ALUCW-1:0] alu_control,
    output logic             instr_done,
    output logic             illegal
);

    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_R      = 7'b0110011;
    localparam logic [OPW-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPW-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [ALUCW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCW-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCW-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCW-1:0] ALU_SLT = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BEQ
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    state_t state;
    state_t state_next;
    logic [ALUCW-1:0] alu_op;

    // State register and registered end-of-instruction pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            instr_done <= 1'b0;
        end else begin
            state      <= state_next;
            instr_done <= (state_next == S_FETCH) &&
                          (state != S_FETCH);
        end
    end

    // ALU operation for the execute states, chosen by funct3
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: begin
                if (state == S_EXECR && funct7b5)
                    alu_op = ALU_SUB;
            end
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

    // Next-state and datapath controls, enables gated by reset
    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        unique case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready)
                    state_next = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  state_next = S_MEMADR;
                    OP_R:      state_next = S_EXECR;
                    OP_IMM:    state_next = S_EXECI;
                    OP_JAL:    state_next = S_JAL;
                    OP_BRANCH: state_next = S_BEQ;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    default:   state_next = S_HALT;
`else
                    default:   state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (opcode == OP_STORE)
                    state_next = S_MEMWRITE;
                else
                    state_next = S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready)
                    state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = alu_op;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_op;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = ALU_SUB;
                pc_write    = zero;
                state_next  = S_FETCH;
            end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal    = 1'b1;
                state_next = S_HALT;
            end
`endif
            default: state_next = S_FETCH;
        endcase

        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the multicycle control FSM.
// Build with MULTICYCLE_ILLEGAL_TRAP_EN to cover the halt variant.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       instr_done;
    logic       illegal;

    int ncmp;
    int nerr;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write,adr_src,mem_write,ir_write,reg_write,
    //  result_src,alu_src_a,alu_src_b,alu_control,instr_done,illegal}
    logic [15:0] outs;
    assign outs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_control,
                   instr_done, illegal};

    function automatic logic [15:0] ev(
        input logic pw, input logic ad, input logic mw,
        input logic iw, input logic rw, input logic [1:0] rs,
        input logic [1:0] sa, input logic [1:0] sb,
        input logic [2:0] ac, input logic dn, input logic il);
        return {pw, ad, mw, iw, rw, rs, sa, sb, ac, dn, il};
    endfunction

    // Frequently used hand-derived output vectors
    logic [15:0] V_F_GO, V_F_IDLE, V_F_DONE, V_DEC, V_ALUWB;
    logic [15:0] V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR, V_MEMWR_RST;

    initial begin
        V_F_GO     = ev(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,0,0);
        V_F_IDLE   = ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,0);
        V_F_DONE   = ev(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,1,0);
        V_DEC      = ev(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,0);
        V_ALUWB    = ev(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,0,0);
        V_MEMADR   = ev(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0);
        V_MEMRD    = ev(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
        V_MEMWB    = ev(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,0,0);
        V_MEMWR    = ev(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
        V_MEMWR_RST = ev(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,0,0);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ncmp++;
        if (outs !== V_F_IDLE) begin
            $display("FAIL reset_held: got %h want %h", outs, V_F_IDLE);
            nerr++;
        end
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        ncmp++;
        if (outs !== V_F_IDLE) begin
            $display("FAIL reset_release: got %h want %h", outs, V_F_IDLE);
            nerr++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype_sub();
        logic [15:0] e [0:4];
        logic        m [0:4];
        e = '{V_F_GO, V_DEC,
              ev(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0),
              V_ALUWB, V_F_DONE};
        m = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b0110011;
        funct3 = 3'b000;
        funct7b5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_ready = m[i];
            #1;
            ncmp++;
            if (outs !== e[i]) begin
                $display("FAIL rtype_sub c%0d: got %h want %h", i, outs, e[i]);
                nerr++;
            end
            ncmp++;
            if (imm_src !== 2'b00) begin
                $display("FAIL rtype_imm c%0d: got %b want 00", i, imm_src);
                nerr++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [15:0] e [0:8];
        logic        m [0:8];
        e = '{V_F_GO, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD,
              V_MEMRD, V_MEMRD, V_MEMWB, V_F_DONE};
        m = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 7'b0000011;
        funct3 = 3'b010;
        funct7b5 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mem_ready = m[i];
            #1;
            ncmp++;
            if (outs !== e[i]) begin
                $display("FAIL load c%0d: got %h want %h", i, outs, e[i]);
                nerr++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_wait();
        logic [15:0] e [0:6];
        logic        m [0:6];
        e = '{V_F_GO, V_DEC, V_MEMADR, V_MEMWR, V_MEMWR,
              V_MEMWR, V_F_DONE};
        m = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        opcode = 7'b0100011;
        funct3 = 3'b010;
        for (int i = 0; i < 7; i++) begin
            mem_ready = m[i];
            #1;
            ncmp++;
            if (outs !== e[i]) begin
                $display("FAIL store c%0d: got %h want %h", i, outs, e[i]);
                nerr++;
            end
            ncmp++;
            if (imm_src !== 2'b01) begin
                $display("FAIL store_imm c%0d: got %b want 01", i, imm_src);
                nerr++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq(input logic z);
        logic [15:0] e [0:3];
        logic        m [0:3];
        e = '{V_F_GO, V_DEC,
              ev(z,0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0),
              V_F_DONE};
        m = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode = 7'b1100011;
        funct3 = 3'b000;
        zero = z;
        for (int i = 0; i < 4; i++) begin
            mem_ready = m[i];
            #1;
            ncmp++;
            if (outs !== e[i]) begin
                $display("FAIL beq z%0b c%0d: got %h want %h", z, i, outs, e[i]);
                nerr++;
            end
            ncmp++;
            if (imm_src !== 2'b10) begin
                $display("FAIL beq_imm c%0d: got %b want 10", i, imm_src);
                nerr++;
            end
            @(posedge clk); #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_jal();
        logic [15:0] e [0:4];
        logic        m [0:4];
        e = '{V_F_GO, V_DEC,
              ev(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,0,0),
              V_ALUWB, V_F_DONE};
        m = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        opcode = 7'b1101111;
        for (int i = 0; i < 5; i++) begin
            mem_ready = m[i];
            #1;
            ncmp++;
            if (outs !== e[i]) begin
                $display("FAIL jal c%0d: got %h want %h", i, outs, e[i]);
                nerr++;
            end
            ncmp++;
            if (imm_src !== 2'b11) begin
                $display("FAIL jal_imm c%0d: got %b want 11", i, imm_src);
                nerr++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] op [0:7];
        logic [2:0] f3 [0:7];
        logic       f7 [0:7];
        logic [2:0] ac [0:7];
        logic [1:0] sb;
        logic [15:0] e;
        op = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011,
               7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011};
        f3 = '{3'b000, 3'b000, 3'b010, 3'b110,
               3'b111, 3'b001, 3'b100, 3'b111};
        f7 = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ac = '{3'b000, 3'b000, 3'b101, 3'b011,
               3'b010, 3'b000, 3'b000, 3'b010};
        for (int k = 0; k < 8; k++) begin
            opcode = op[k];
            funct3 = f3[k];
            funct7b5 = f7[k];
            sb = (op[k] == 7'b0110011) ? 2'b00 : 2'b01;
            mem_ready = 1'b1;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            @(posedge clk); #1;
            e = ev(0,0,0,0,0,2'b00,2'b10,sb,ac[k],0,0);
            ncmp++;
            if (outs !== e) begin
                $display("FAIL alu_dec k%0d: got %h want %h", k, outs, e);
                nerr++;
            end
            @(posedge clk); #1;
            ncmp++;
            if (outs !== V_ALUWB) begin
                $display("FAIL alu_wb k%0d: got %h want %h", k, outs, V_ALUWB);
                nerr++;
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_store();
        logic [15:0] e [0:5];
        logic        m [0:5];
        logic        r [0:5];
        e = '{V_F_GO, V_DEC, V_MEMADR, V_MEMWR_RST,
              V_F_IDLE, V_F_IDLE};
        m = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        opcode = 7'b0100011;
        funct3 = 3'b010;
        for (int i = 0; i < 6; i++) begin
            mem_ready = m[i];
            rst_n = r[i];
            #1;
            ncmp++;
            if (outs !== e[i]) begin
                $display("FAIL rst_store c%0d: got %h want %h", i, outs, e[i]);
                nerr++;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        logic [15:0] vh;
        vh = ev(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,0,1);
        opcode = 7'b1111111;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        #1;
        ncmp++;
        if (outs !== V_F_GO) begin
            $display("FAIL ill_fetch: got %h want %h", outs, V_F_GO);
            nerr++;
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1;
        ncmp++;
        if (outs !== V_DEC) begin
            $display("FAIL ill_decode: got %h want %h", outs, V_DEC);
            nerr++;
        end
        @(posedge clk); #1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            #1;
            ncmp++;
            if (outs !== vh) begin
                $display("FAIL halt c%0d: got %h want %h", i, outs, vh);
                nerr++;
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        ncmp++;
        if (outs !== V_F_IDLE) begin
            $display("FAIL halt_exit: got %h want %h", outs, V_F_IDLE);
            nerr++;
        end
`else
        ncmp++;
        if (outs !== V_F_DONE) begin
            $display("FAIL ill_nop: got %h want %h", outs, V_F_DONE);
            nerr++;
        end
        ncmp++;
        if (outs === vh) begin
            $display("FAIL ill_flag: got %h want not %h", outs, vh);
            nerr++;
        end
        @(posedge clk); #1;
        ncmp++;
        if (outs !== V_F_IDLE) begin
            $display("FAIL ill_idle: got %h want %h", outs, V_F_IDLE);
            nerr++;
        end
`endif
        ncmp++;
        if (imm_src !== 2'b00) begin
            $display("FAIL ill_imm: got %b want 00", imm_src);
            nerr++;
        end
    endtask

    initial begin
        ncmp = 0;
        nerr = 0;
        test_reset();
        test_rtype_sub();
        test_load_wait();
        test_store_wait();
        test_beq(1'b1);
        test_beq(1'b0);
        test_jal();
        test_alu_decode();
        test_reset_in_store();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
